// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver for 8N1 frames (LSB first,
// idle-high line). It recovers each byte from a transmitter's serial output
// and flags frames whose stop bit is sampled low.
//
// Ports:
//   CP        in   system clock, rising edge
//   RST       in   asynchronous, active-high reset
//   Rx        in   serial line, asynchronous to CP, idle high
//   Data      out  [7:0] last correctly framed byte
//   Valid     out  one-cycle pulse, Data updated this cycle
//   FrameErr  out  one-cycle pulse, stop bit sampled low
//   Busy      out  high whenever the receiver is not in IDLE
//
// Parameters:
//   CLKS_PER_BIT  CP cycles per bit period (>= 4)
//   HALF_BIT      cycles from the start-bit edge to its centre sample point

`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       Rx,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // BREAK is the power-up state: the line must be seen high before a start
    // bit is accepted, so a line held low after reset or after a framing
    // error cannot fake a frame.
    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          rs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Two-flop synchroniser; resets to the idle (high) level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values and the two stages really form a 2-cycle delay.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Rx;
            sync2_q <= sync1_q;
        end
    end

    assign rs = sync2_q;

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state_q <= S_BREAK;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_BREAK: begin
                if (rs) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (!rs) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            // Re-check the start bit at its centre; a high line here was a
            // glitch and is dropped silently.
            S_START: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == HALF_LAST) begin
                    if (!rs) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            // Counting starts from the start-bit centre, so each full bit
            // period lands on the centre of the next data bit.
            S_DATA: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rs, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rs) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            default: begin
                state_d = S_BREAK;
            end
        endcase
    end

    assign Data     = data_q;
    assign Valid    = valid_q;
    assign FrameErr = ferr_q;
    assign Busy     = (state_q != S_IDLE);

endmodule
